// File: rtl/lpif_tx_pkg.sv
// Shared constants and flit helpers for the LPIF response transmit path.
package lpif_tx_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int CRC_W_DEF  = 16;
    localparam int FLIT_W     = DATA_W_DEF + CRC_W_DEF;

    // Grant encoding, also the encoding of last_grant
    localparam logic GNT_NDR = 1'b0;
    localparam logic GNT_DRS = 1'b1;

    // Burst counter width; MAX_BURST is limited to 1..15
    localparam int BURST_W = 4;

    // Payload portion of a {crc, data} flit
    function automatic logic [DATA_W_DEF-1:0] flit_data(input logic [FLIT_W-1:0] flit);
        return flit[DATA_W_DEF-1:0];
    endfunction

    // CRC portion of a {crc, data} flit
    function automatic logic [CRC_W_DEF-1:0] flit_crc(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1:DATA_W_DEF];
    endfunction

endpackage

// File: rtl/lpif_tx_burst_arb.sv
// Burst-limited round-robin between NDR and DRS requesters.
// A grant is only issued to a valid requester while load_ok is high,
// so a grant is itself the handshake.
module lpif_tx_burst_arb
    import lpif_tx_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_ok,
    input  logic ndr_valid,
    input  logic drs_valid,
    output logic ndr_gnt,
    output logic drs_gnt,
    output logic last_grant
);

    localparam logic [BURST_W-1:0] MAX_BURST_L = BURST_W'(MAX_BURST);

    logic               last_grant_q;
    logic               last_grant_d;
    logic [BURST_W-1:0] burst_cnt_q;
    logic [BURST_W-1:0] burst_cnt_d;

    logic sel;
    logic any_req;
    logic handshake;

    // Pick a requester and update the burst bookkeeping on a handshake
    always_comb begin
        sel          = last_grant_q;
        any_req      = 1'b0;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;

        case ({ndr_valid, drs_valid})
            2'b10: begin
                sel     = GNT_NDR;
                any_req = 1'b1;
            end
            2'b01: begin
                sel     = GNT_DRS;
                any_req = 1'b1;
            end
            2'b11: begin
                sel     = (burst_cnt_q >= MAX_BURST_L) ? ~last_grant_q : last_grant_q;
                any_req = 1'b1;
            end
            default: begin
                sel     = last_grant_q;
                any_req = 1'b0;
            end
        endcase

        ndr_gnt   = load_ok & any_req & (sel == GNT_NDR);
        drs_gnt   = load_ok & any_req & (sel == GNT_DRS);
        handshake = ndr_gnt | drs_gnt;

        if (handshake) begin
            if (sel == last_grant_q) begin
                if (burst_cnt_q < MAX_BURST_L) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end
            end else begin
                last_grant_d = sel;
                burst_cnt_d  = BURST_W'(1);
            end
        end
    end

    // Arbitration state register; NDR owns the first tie after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GNT_NDR;
            burst_cnt_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/lpif_rsp_tx_arbiter.sv
// LPIF transmit scheduler: shares the adapter TX path between the NDR and
// DRS response sources through a one-entry output register.
module lpif_rsp_tx_arbiter
    import lpif_tx_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int CRC_W     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    link_up,
    input  logic                    ndr_valid,
    input  logic [DATA_W+CRC_W-1:0] ndr_flit,
    output logic                    ndr_ready,
    input  logic                    drs_valid,
    input  logic [DATA_W+CRC_W-1:0] drs_flit,
    output logic                    drs_ready,
    input  logic                    pl_trdy,
    output logic                    lp_valid,
    output logic                    lp_irdy,
    output logic [DATA_W-1:0]       lp_data,
    output logic [CRC_W-1:0]        lp_crc,
    output logic                    lp_crc_valid,
    output logic [15:0]             tx_cnt,
    output logic                    last_grant
);

    localparam int FLIT_LW = DATA_W + CRC_W;

    logic               full_q;
    logic               full_d;
    logic [FLIT_LW-1:0] obuf_q;
    logic [FLIT_LW-1:0] obuf_d;
    logic [15:0]        tx_cnt_q;
    logic [15:0]        tx_cnt_d;

    logic load_ok;
    logic xfer;
    logic ndr_gnt;
    logic drs_gnt;
    logic load;

    // The output register may refill in the same cycle it drains
    assign load_ok = link_up & (~full_q | pl_trdy);
    assign xfer    = full_q & pl_trdy;

    lpif_tx_burst_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_ok    (load_ok),
        .ndr_valid  (ndr_valid),
        .drs_valid  (drs_valid),
        .ndr_gnt    (ndr_gnt),
        .drs_gnt    (drs_gnt),
        .last_grant (last_grant)
    );

    assign ndr_ready = ndr_gnt;
    assign drs_ready = drs_gnt;
    assign load      = ndr_gnt | drs_gnt;

    // Load on a handshake, otherwise drain on transfer and keep the old data
    always_comb begin
        full_d   = full_q;
        obuf_d   = obuf_q;
        tx_cnt_d = tx_cnt_q;

        if (load) begin
            full_d = 1'b1;
            obuf_d = drs_gnt ? drs_flit : ndr_flit;
        end else if (xfer) begin
            full_d = 1'b0;
        end

        if (xfer) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
    end

    // Output register and accepted-flit counter; reset discards any held flit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q   <= 1'b0;
            obuf_q   <= '0;
            tx_cnt_q <= '0;
        end else begin
            full_q   <= full_d;
            obuf_q   <= obuf_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign lp_valid     = full_q;
    assign lp_irdy      = full_q;
    assign lp_crc_valid = full_q;
    assign tx_cnt       = tx_cnt_q;

    // Split the held flit into payload and CRC side-band
    generate
        if (DATA_W == DATA_W_DEF && CRC_W == CRC_W_DEF) begin : g_pkg_slice
            assign lp_data = flit_data(obuf_q);
            assign lp_crc  = flit_crc(obuf_q);
        end else begin : g_generic_slice
            assign lp_data = obuf_q[DATA_W-1:0];
            assign lp_crc  = obuf_q[FLIT_LW-1:DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_lpif_rsp_tx_arbiter.sv
// Scoreboard bench for lpif_rsp_tx_arbiter: sources are fed from queues,
// expected flits are queued in hand-computed order and popped by a monitor.
module tb_lpif_rsp_tx_arbiter;

    localparam int DATA_W = 512;
    localparam int CRC_W  = 16;
    localparam int FLIT_W = DATA_W + CRC_W;

    logic              clk;
    logic              reset_n;
    logic              link_up;
    logic              ndr_valid;
    logic [FLIT_W-1:0] ndr_flit;
    logic              ndr_ready;
    logic              drs_valid;
    logic [FLIT_W-1:0] drs_flit;
    logic              drs_ready;
    logic              pl_trdy;
    logic              lp_valid;
    logic              lp_irdy;
    logic [DATA_W-1:0] lp_data;
    logic [CRC_W-1:0]  lp_crc;
    logic              lp_crc_valid;
    logic [15:0]       tx_cnt;
    logic              last_grant;

    int checkCount = 0;
    int errorCount = 0;

    logic [FLIT_W-1:0] ndrSrc[$];
    logic [FLIT_W-1:0] drsSrc[$];
    logic [FLIT_W-1:0] expQ[$];
    bit                floodMode = 1'b0;
    logic [FLIT_W-1:0] floodFlit;

    lpif_rsp_tx_arbiter #(
        .DATA_W    (DATA_W),
        .CRC_W     (CRC_W),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .link_up      (link_up),
        .ndr_valid    (ndr_valid),
        .ndr_flit     (ndr_flit),
        .ndr_ready    (ndr_ready),
        .drs_valid    (drs_valid),
        .drs_flit     (drs_flit),
        .drs_ready    (drs_ready),
        .pl_trdy      (pl_trdy),
        .lp_valid     (lp_valid),
        .lp_irdy      (lp_irdy),
        .lp_data      (lp_data),
        .lp_crc       (lp_crc),
        .lp_crc_valid (lp_crc_valid),
        .tx_cnt       (tx_cnt),
        .last_grant   (last_grant)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, recognisable flit per source and index
    function automatic logic [FLIT_W-1:0] makeFlit(input bit isDrs, input int idx);
        logic [31:0] word;
        logic [15:0] crc;
        word = (isDrs ? 32'hD000_0000 : 32'hA000_0000) + 32'(idx);
        crc  = {(isDrs ? 8'hD5 : 8'hA5), 8'(idx)};
        return {crc, {16{word}}};
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit isDrs, input int idx);
        if (isDrs) drsSrc.push_back(makeFlit(1'b1, idx));
        else       ndrSrc.push_back(makeFlit(1'b0, idx));
    endtask

    task automatic expectFlit(input bit isDrs, input int idx);
        expQ.push_back(makeFlit(isDrs, idx));
    endtask

    task automatic clearQueues();
        ndrSrc.delete();
        drsSrc.delete();
        expQ.delete();
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        clearQueues();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic waitReady(input bit isDrs, input string name, input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if ((isDrs ? drs_ready : ndr_ready) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: ready never seen within %0d cycles", name, maxCycles);
        end
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (lp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: lp_valid never seen within %0d cycles", name, maxCycles);
        end
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        bit done = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && lp_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: %0d flits still pending after %0d cycles", name, expQ.size(), maxCycles);
        end
    endtask

    // Source driver: offers queue heads and retires them after a handshake
    initial begin
        bit hsNdr;
        bit hsDrs;
        ndr_valid = 1'b0;
        drs_valid = 1'b0;
        ndr_flit  = '0;
        drs_flit  = '0;
        forever begin
            @(negedge clk);
            hsNdr = (ndr_valid === 1'b1) && (ndr_ready === 1'b1);
            hsDrs = (drs_valid === 1'b1) && (drs_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!floodMode && hsNdr && ndrSrc.size() > 0) void'(ndrSrc.pop_front());
            if (hsDrs && drsSrc.size() > 0) void'(drsSrc.pop_front());
            ndr_valid = floodMode || (ndrSrc.size() > 0);
            ndr_flit  = floodMode ? floodFlit : ((ndrSrc.size() > 0) ? ndrSrc[0] : '0);
            drs_valid = (drsSrc.size() > 0);
            drs_flit  = (drsSrc.size() > 0) ? drsSrc[0] : '0;
        end
    end

    // Monitor: every accepted flit must be the next expected one
    initial begin
        logic [FLIT_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && !floodMode && lp_valid === 1'b1 && pl_trdy === 1'b1) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    errorCount++;
                    $display("[TB] FAIL unexpected_flit: got data %0h crc %0h with nothing expected", lp_data, lp_crc);
                end else begin
                    exp = expQ.pop_front();
                    if (lp_data !== exp[DATA_W-1:0] || lp_crc !== exp[FLIT_W-1:DATA_W]) begin
                        errorCount++;
                        $display("[TB] FAIL flit_order: got crc %0h data %0h expected crc %0h data %0h",
                                 lp_crc, lp_data, exp[FLIT_W-1:DATA_W], exp[DATA_W-1:0]);
                    end
                end
                checkOutput("lp_irdy_follows_valid", {lp_irdy, lp_crc_valid}, 2'b11);
            end
        end
    end

    initial begin
        int n;
        floodFlit = makeFlit(1'b0, 255);
        reset_n   = 1'b1;
        link_up   = 1'b1;
        pl_trdy   = 1'b0;
        #2;

        // Reset state
        applyReset();
        @(negedge clk);
        checkOutput("reset_lp_valid", {lp_valid, lp_irdy, lp_crc_valid}, 3'b000);
        checkOutput("reset_lp_data", lp_data, '0);
        checkOutput("reset_tx_cnt", tx_cnt, 16'd0);
        checkOutput("reset_last_grant", last_grant, 1'b0);

        // NDR only, 8 flits back to back
        $display("[TB] test: NDR only");
        applyReset();
        pl_trdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, i);
            expectFlit(1'b0, i);
        end
        waitReady(1'b0, "t1_first_ready", 20);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t1_valid_run", lp_valid, 1'b1);
        end
        @(negedge clk);
        checkOutput("t1_valid_end", lp_valid, 1'b0);
        checkOutput("t1_tx_cnt", tx_cnt, 16'd8);

        // Both requesters valid, burst of 4 each
        $display("[TB] test: round robin bursts");
        applyReset();
        pl_trdy = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, i);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i);
        for (int i = 0; i < 4; i++) expectFlit(1'b0, i);
        for (int i = 0; i < 4; i++) expectFlit(1'b1, i);
        for (int i = 4; i < 8; i++) expectFlit(1'b0, i);
        for (int i = 4; i < 6; i++) expectFlit(1'b1, i);
        waitDrain("t2_drain", 100);
        checkOutput("t2_tx_cnt", tx_cnt, 16'd14);
        checkOutput("t2_last_grant", last_grant, 1'b1);

        // Back-pressure holds the output register
        $display("[TB] test: back-pressure");
        applyReset();
        pl_trdy = 1'b0;
        applyStimulus(1'b0, 10);
        applyStimulus(1'b0, 11);
        expectFlit(1'b0, 10);
        expectFlit(1'b0, 11);
        waitValid("t3_fill", 20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_data_stable", lp_data, makeFlit(1'b0, 10) >> 0);
            checkOutput("t3_ready_low", {ndr_ready, drs_ready}, 2'b00);
            @(negedge clk);
        end
        @(posedge clk);
        #1 pl_trdy = 1'b1;
        @(negedge clk);
        checkOutput("t3_same_cycle_load", ndr_ready, 1'b1);
        waitDrain("t3_drain", 50);
        checkOutput("t3_tx_cnt", tx_cnt, 16'd2);

        // Link drop while a flit is held
        $display("[TB] test: link drop");
        applyReset();
        pl_trdy = 1'b0;
        link_up = 1'b1;
        applyStimulus(1'b0, 20);
        applyStimulus(1'b0, 21);
        applyStimulus(1'b1, 22);
        expectFlit(1'b0, 20);
        expectFlit(1'b0, 21);
        expectFlit(1'b1, 22);
        waitValid("t4_fill", 20);
        @(posedge clk);
        #1 link_up = 1'b0;
        @(negedge clk);
        checkOutput("t4_ready_low_hold", {ndr_ready, drs_ready}, 2'b00);
        @(posedge clk);
        #1 pl_trdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t4_ready_low_down", {ndr_ready, drs_ready}, 2'b00);
        end
        checkOutput("t4_tx_cnt_outage", tx_cnt, 16'd1);
        checkOutput("t4_valid_cleared", lp_valid, 1'b0);
        @(posedge clk);
        #1 link_up = 1'b1;
        waitDrain("t4_drain", 50);
        checkOutput("t4_tx_cnt", tx_cnt, 16'd3);
        checkOutput("t4_last_grant", last_grant, 1'b1);

        // Asynchronous reset in the middle of an NDR burst
        $display("[TB] test: reset mid-burst");
        applyReset();
        pl_trdy = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 30 + i);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b1, 31);
        expectFlit(1'b0, 30);
        expectFlit(1'b0, 31);
        waitReady(1'b0, "t5_first_ready", 20);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        clearQueues();
        #1;
        checkOutput("t5_valid_zero", {lp_valid, lp_irdy, lp_crc_valid}, 3'b000);
        checkOutput("t5_data_zero", lp_data, '0);
        checkOutput("t5_crc_zero", lp_crc, '0);
        checkOutput("t5_tx_cnt_zero", tx_cnt, 16'd0);
        checkOutput("t5_last_grant_zero", last_grant, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 40);
        expectFlit(1'b0, 40);
        expectFlit(1'b1, 40);
        waitDrain("t5_drain", 50);
        checkOutput("t5_tx_cnt_after", tx_cnt, 16'd2);
        checkOutput("t5_last_grant_after", last_grant, 1'b1);

        // Counter wrap through continuous NDR traffic
        $display("[TB] test: counter wrap");
        applyReset();
        floodMode = 1'b1;
        pl_trdy   = 1'b1;
        n = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (lp_valid === 1'b1) n++;
            if (n == 65535) begin
                pl_trdy = 1'b0;
                break;
            end
        end
        if (n != 65535) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL t6_flood: only %0d presented flits, needed 65535", n);
        end
        @(negedge clk);
        checkOutput("t6_tx_cnt_fffe", tx_cnt, 16'hFFFE);
        pl_trdy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        pl_trdy   = 1'b0;
        floodMode = 1'b0;
        @(negedge clk);
        checkOutput("t6_tx_cnt_wrap", tx_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
